// File: rtl/dma_snd_out.sv
// DMA sound playback: strobe-loaded word FIFO drained at the sample rate into 8-bit L/R samples.
// Optional build macro DMASND_UNDERRUN_EN zeroes outputs on underrun and adds the sticky unr flag.
module dma_snd_out #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DIV_BASE = 640
) (
  input  logic        clk32,
  input  logic        res,
  input  logic        sndon,
  input  logic        mono,
  input  logic [1:0]  rate,
  input  logic        sload_n,
  input  logic [15:0] din,
  output logic        sreq,
  output logic [7:0]  snd_l,
  output logic [7:0]  snd_r,
  output logic [2:0]  level,
  output logic        ovf
`ifdef DMASND_UNDERRUN_EN
  ,
  output logic        unr
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne = 1;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]    level_q, level_d;
  logic          sload_q, sload_qq;
  logic [12:0]   div_q, div_d, period;
  logic [1:0]    rate_q, rate_d;
  logic          bsel_q, bsel_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    snd_l_q, snd_l_d, snd_r_q, snd_r_d;
  logic          push_req, push, pop, tick, full, empty;
  logic [15:0]   head;
`ifdef DMASND_UNDERRUN_EN
  logic          unr_q, unr_d, sndon_q;
`endif

  assign full     = (level_q == 3'(DEPTH));
  assign empty    = (level_q == 3'd0);
  assign push_req = sload_qq & ~sload_q & sndon;
  assign push     = push_req & ~full;
  assign period   = 13'(DIV_BASE << (2'd3 - rate_q));
  assign tick     = sndon & (div_q == period - 13'd1);
  assign head     = mem_q[rd_ptr_q];
  // In mono, the first byte of a word leaves it in the FIFO.
  assign pop      = tick & ~empty & (~mono | bsel_q);

  assign sreq  = sndon & ~res & (level_q < 3'(DEPTH - 1));
  assign snd_l = snd_l_q;
  assign snd_r = snd_r_q;
  assign level = level_q;
  assign ovf   = ovf_q;
`ifdef DMASND_UNDERRUN_EN
  assign unr   = unr_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    bsel_d   = bsel_q;
    snd_l_d  = snd_l_q;
    snd_r_d  = snd_r_q;
    ovf_d    = ovf_q | (push_req & full);
    div_d    = tick ? 13'd0 : div_q + 13'd1;
    rate_d   = tick ? rate : rate_q;
`ifdef DMASND_UNDERRUN_EN
    unr_d    = (sndon & ~sndon_q) ? 1'b0 : unr_q;
`endif

    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    if (push & ~pop)      level_d = level_q + 3'd1;
    else if (pop & ~push) level_d = level_q - 3'd1;

    if (tick) begin
      if (empty) begin
`ifdef DMASND_UNDERRUN_EN
        snd_l_d = 8'd0;
        snd_r_d = 8'd0;
        unr_d   = 1'b1;
`endif
      end else if (mono & ~bsel_q) begin
        snd_l_d = head[15:8];
        snd_r_d = head[15:8];
        bsel_d  = 1'b1;
      end else if (mono) begin
        snd_l_d = head[7:0];
        snd_r_d = head[7:0];
        bsel_d  = 1'b0;
      end else begin
        snd_l_d = head[15:8];
        snd_r_d = head[7:0];
        bsel_d  = 1'b0;
      end
    end

    if (!sndon) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = 3'd0;
      bsel_d   = 1'b0;
      div_d    = 13'd0;
      rate_d   = rate;
      snd_l_d  = 8'd0;
      snd_r_d  = 8'd0;
    end
  end

  always_ff @(posedge clk32) begin
    if (res) begin
      sload_q  <= 1'b1;
      sload_qq <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 3'd0;
      div_q    <= 13'd0;
      rate_q   <= rate;
      bsel_q   <= 1'b0;
      ovf_q    <= 1'b0;
      snd_l_q  <= 8'd0;
      snd_r_q  <= 8'd0;
`ifdef DMASND_UNDERRUN_EN
      unr_q    <= 1'b0;
      sndon_q  <= 1'b0;
`endif
    end else begin
      sload_q  <= sload_n;
      sload_qq <= sload_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      div_q    <= div_d;
      rate_q   <= rate_d;
      bsel_q   <= bsel_d;
      ovf_q    <= ovf_d;
      snd_l_q  <= snd_l_d;
      snd_r_q  <= snd_r_d;
`ifdef DMASND_UNDERRUN_EN
      unr_q    <= unr_d;
      sndon_q  <= sndon;
`endif
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk32) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule
